// File: rtl/truth_table_sweeper.sv
// Truth-table sweeper: drives every input vector to a lab logic function, samples its output
// after a settle interval and builds the table. Optional compare logic under `SWEEP_COMPARE_EN`.
module truth_table_sweeper #(
  parameter int N_IN          = 3,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic [N_IN-1:0]      vec,
  input  logic                 f_in,
  output logic [2**N_IN-1:0]   table_out,
  output logic                 busy,
  output logic                 done
`ifdef SWEEP_COMPARE_EN
  ,
  input  logic [2**N_IN-1:0]   exp_table,
  output logic                 match
`endif
);

  localparam int TW = 2**N_IN;
  localparam logic [7:0]      CNT_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [N_IN-1:0] VEC_LAST = '1;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    DONE
  } state_t;

  state_t          state, state_d;
  logic [N_IN-1:0] vec_d;
  logic [7:0]      cnt, cnt_d;
  logic [TW-1:0]   table_d;

`ifdef SWEEP_COMPARE_EN
  logic            match_d;
`endif

  // Next-state and datapath updates; the captured bit is folded into table_d so the
  // final comparison sees the complete table.
  always_comb begin
    state_d = state;
    vec_d   = vec;
    cnt_d   = cnt;
    table_d = table_out;
`ifdef SWEEP_COMPARE_EN
    match_d = match;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          vec_d   = '0;
          cnt_d   = '0;
          table_d = '0;
`ifdef SWEEP_COMPARE_EN
          match_d = 1'b0;
`endif
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        cnt_d = cnt + 8'd1;
        if (cnt == CNT_LAST) begin
          state_d = SAMPLE;
        end
      end
      SAMPLE: begin
        table_d[vec] = f_in;
        if (vec == VEC_LAST) begin
`ifdef SWEEP_COMPARE_EN
          match_d = (table_d == exp_table);
`endif
          state_d = DONE;
        end else begin
          vec_d   = vec + N_IN'(1);
          cnt_d   = '0;
          state_d = SETTLE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // busy and done are decoded from the next state so they line up with the state they describe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      vec       <= '0;
      cnt       <= '0;
      table_out <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_d;
      vec       <= vec_d;
      cnt       <= cnt_d;
      table_out <= table_d;
      busy      <= (state_d == SETTLE) || (state_d == SAMPLE);
      done      <= (state_d == DONE);
    end
  end

`ifdef SWEEP_COMPARE_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      match <= 1'b0;
    end else begin
      match <= match_d;
    end
  end
`endif

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Self-checking bench for truth_table_sweeper: random and fixed lab functions compared against
// a table model built from the function definitions. Compare tests run when SWEEP_COMPARE_EN is defined.
module tb_truth_table_sweeper;

  localparam int N_IN   = 3;
  localparam int SETTLE = 4;
  localparam int TW     = 2**N_IN;
  localparam int LAT    = TW * (SETTLE + 1) + 1;
  localparam int PERIOD = LAT + 1;
  localparam int LIMIT  = 500;

  localparam int K_MAJ  = 0;
  localparam int K_PAR  = 1;
  localparam int K_ZERO = 2;
  localparam int K_ONE  = 3;
  localparam int K_RAND = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic [N_IN-1:0] vec;
  logic            f_in;
  logic [TW-1:0]   table_out;
  logic            busy;
  logic            done;
  logic [TW-1:0]   exp_table;
  logic            match;

  int              kind;
  logic [TW-1:0]   rnd;
  int              tests_run    = 0;
  int              tests_failed = 0;

  always #5 clk = ~clk;

  // Function under test, written as gate logic on the a/b/c inputs.
  always_comb begin
    f_in = 1'b0;
    case (kind)
      K_MAJ:   f_in = (vec[2] & vec[1]) | (vec[1] & vec[0]) | (vec[2] & vec[0]);
      K_PAR:   f_in = vec[2] ^ vec[1] ^ vec[0];
      K_ONE:   f_in = 1'b1;
      K_RAND:  f_in = rnd[vec];
      default: f_in = 1'b0;
    endcase
  end

  truth_table_sweeper #(.N_IN(N_IN), .SETTLE_CYCLES(SETTLE)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .vec       (vec),
    .f_in      (f_in),
    .table_out (table_out),
    .busy      (busy),
    .done      (done)
`ifdef SWEEP_COMPARE_EN
    ,
    .exp_table (exp_table),
    .match     (match)
`endif
  );

`ifndef SWEEP_COMPARE_EN
  assign match = 1'b0;
`endif

  function automatic logic [TW-1:0] model_table(input int k, input logic [TW-1:0] r);
    logic [TW-1:0] t;
    t = '0;
    for (int i = 0; i < TW; i++) begin
      case (k)
        K_MAJ:   t[i] = ($countones(i) >= 2);
        K_PAR:   t[i] = ($countones(i) % 2) == 1;
        K_ONE:   t[i] = 1'b1;
        K_RAND:  t[i] = r[i];
        default: t[i] = 1'b0;
      endcase
    end
    return t;
  endfunction

  // Starts a sweep and counts cycles from the start-sampling cycle to the done cycle.
  task automatic applyStimulus(input int k, input bit keep_start, input int pulse_at,
                               output int lat, output int busy_bad,
                               output logic [N_IN-1:0] vec_at_done, output logic busy_at_done);
    @(negedge clk);
    kind     = k;
    start    = 1'b1;
    lat      = 0;
    busy_bad = 0;
    for (int i = 0; i < LIMIT; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (!keep_start) start = (lat == pulse_at);
      if (done) break;
      if (!busy) busy_bad++;
    end
    if (!done) lat = -1;
    vec_at_done  = vec;
    busy_at_done = busy;
    if (!keep_start) start = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (vec !== '0) begin tests_failed++; $display("[TB] FAIL reset_vec got %0h want 0", vec); end
    tests_run++;
    if (table_out !== '0) begin tests_failed++; $display("[TB] FAIL reset_table got %0h want 0", table_out); end
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    tests_run++;
    if (done !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_done got %b want 0", done); end
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_majority;
    int lat, bb;
    logic [N_IN-1:0] v;
    logic b;
    logic [TW-1:0] want;
    want = model_table(K_MAJ, '0);
    applyStimulus(K_MAJ, 1'b0, 0, lat, bb, v, b);
    tests_run++;
    if (lat != LAT) begin tests_failed++; $display("[TB] FAIL maj_latency got %0d want %0d", lat, LAT); end
    tests_run++;
    if (table_out !== want) begin tests_failed++; $display("[TB] FAIL maj_table got %0h want %0h", table_out, want); end
    tests_run++;
    if (b !== 1'b0) begin tests_failed++; $display("[TB] FAIL maj_busy_at_done got %b want 0", b); end
    tests_run++;
    if (bb != 0) begin tests_failed++; $display("[TB] FAIL maj_busy_during got %0d low cycles want 0", bb); end
    tests_run++;
    if (v !== N_IN'(TW - 1)) begin tests_failed++; $display("[TB] FAIL maj_vec_at_done got %0d want %0d", v, TW - 1); end
    @(posedge clk);
    #1;
    tests_run++;
    if (done !== 1'b0) begin tests_failed++; $display("[TB] FAIL maj_done_width got %b want 0", done); end
    repeat (5) @(posedge clk);
    #1;
    tests_run++;
    if (table_out !== want || vec !== N_IN'(TW - 1)) begin
      tests_failed++;
      $display("[TB] FAIL maj_hold got table %0h vec %0d want %0h %0d", table_out, vec, want, TW - 1);
    end
  endtask

  task automatic test_parity_then_zero;
    int lat, bb;
    logic [N_IN-1:0] v;
    logic b;
    applyStimulus(K_PAR, 1'b0, 0, lat, bb, v, b);
    tests_run++;
    if (table_out !== model_table(K_PAR, '0)) begin
      tests_failed++;
      $display("[TB] FAIL parity_table got %0h want %0h", table_out, model_table(K_PAR, '0));
    end
    repeat (2) @(negedge clk);
    applyStimulus(K_ZERO, 1'b0, 0, lat, bb, v, b);
    tests_run++;
    if (table_out !== model_table(K_ZERO, '0) || lat != LAT) begin
      tests_failed++;
      $display("[TB] FAIL zero_table got %0h lat %0d want %0h lat %0d", table_out, lat, model_table(K_ZERO, '0), LAT);
    end
  endtask

  task automatic test_random;
    int lat, bb;
    logic [N_IN-1:0] v;
    logic b;
    for (int n = 0; n < 4; n++) begin
      rnd = TW'($urandom);
      repeat (2) @(negedge clk);
      applyStimulus(K_RAND, 1'b0, 0, lat, bb, v, b);
      tests_run++;
      if (table_out !== model_table(K_RAND, rnd) || lat != LAT) begin
        tests_failed++;
        $display("[TB] FAIL rand_table[%0d] got %0h lat %0d want %0h lat %0d", n, table_out, lat, model_table(K_RAND, rnd), LAT);
      end
    end
  endtask

  task automatic test_start_ignored;
    int lat, bb, extra;
    logic [N_IN-1:0] v;
    logic b;
    repeat (2) @(negedge clk);
    applyStimulus(K_MAJ, 1'b0, 10, lat, bb, v, b);
    tests_run++;
    if (lat != LAT) begin tests_failed++; $display("[TB] FAIL ignore_latency got %0d want %0d", lat, LAT); end
    extra = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      if (done || busy) extra++;
    end
    tests_run++;
    if (extra != 0) begin tests_failed++; $display("[TB] FAIL ignore_requeue got %0d active cycles want 0", extra); end
  endtask

  task automatic test_reset_mid;
    int lat, bb, seen, dones;
    logic [N_IN-1:0] v;
    logic b;
    @(negedge clk);
    kind  = K_ONE;
    start = 1'b1;
    seen  = 0;
    for (int i = 0; i < LIMIT; i++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (vec == N_IN'(3)) begin seen = 1; break; end
    end
    tests_run++;
    if (seen != 1) begin tests_failed++; $display("[TB] FAIL midreset_reach got %0d want 1", seen); end
    reset = 1'b1;
    #1;
    tests_run++;
    if (vec !== '0 || table_out !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL midreset_clear got vec %0d table %0h busy %b done %b want all 0", vec, table_out, busy, done);
    end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    dones = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      if (done) dones++;
    end
    tests_run++;
    if (dones != 0) begin tests_failed++; $display("[TB] FAIL midreset_done got %0d pulses want 0", dones); end
    applyStimulus(K_MAJ, 1'b0, 0, lat, bb, v, b);
    tests_run++;
    if (table_out !== model_table(K_MAJ, '0) || lat != LAT) begin
      tests_failed++;
      $display("[TB] FAIL midreset_rerun got %0h lat %0d want %0h lat %0d", table_out, lat, model_table(K_MAJ, '0), LAT);
    end
  endtask

  task automatic test_back_to_back;
    int lat, bb;
    logic [N_IN-1:0] v;
    logic b;
    repeat (2) @(negedge clk);
    applyStimulus(K_ONE, 1'b1, 0, lat, bb, v, b);
    tests_run++;
    if (lat != LAT) begin tests_failed++; $display("[TB] FAIL b2b_first got %0d want %0d", lat, LAT); end
    for (int n = 0; n < 2; n++) begin
      applyStimulus(K_ONE, 1'b1, 0, lat, bb, v, b);
      tests_run++;
      if (lat != PERIOD || table_out !== model_table(K_ONE, '0)) begin
        tests_failed++;
        $display("[TB] FAIL b2b_spacing[%0d] got %0d table %0h want %0d %0h", n, lat, table_out, PERIOD, model_table(K_ONE, '0));
      end
    end
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
  endtask

`ifdef SWEEP_COMPARE_EN
  task automatic test_compare;
    int lat, bb;
    logic [N_IN-1:0] v;
    logic b;
    exp_table = model_table(K_MAJ, '0);
    applyStimulus(K_MAJ, 1'b0, 0, lat, bb, v, b);
    tests_run++;
    if (match !== 1'b1) begin tests_failed++; $display("[TB] FAIL cmp_match got %b want 1", match); end
    exp_table = model_table(K_MAJ, '0) ^ TW'(1);
    repeat (2) @(negedge clk);
    applyStimulus(K_MAJ, 1'b0, 0, lat, bb, v, b);
    tests_run++;
    if (match !== 1'b0) begin tests_failed++; $display("[TB] FAIL cmp_mismatch got %b want 0", match); end
  endtask
`endif

  initial begin
    kind      = K_ZERO;
    rnd       = '0;
    exp_table = '0;
    reset     = 1'b1;
    start     = 1'b0;
    test_reset();
    test_majority();
    test_parity_then_zero();
    test_random();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
`ifdef SWEEP_COMPARE_EN
    test_compare();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
